// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;
    localparam int AREQ_PULSE  = 8;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchroniser for asynchronous status inputs.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Qualifies PLL lock and releases staged domain resets in order.
// Optional lock watchdog with pll_areset output: PLL_RST_SEQ_LOCK_TIMEOUT_EN.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STABLE_CYC  = 1000,
    parameter int STAGE_GAP   = 16,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  locked,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_ready,
    output logic                  lock_lost,
    output logic [CNT_W-1:0]      lost_cnt
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
    ,
    output logic                  pll_areset
`endif
);

    localparam int STB_W  = $clog2(STABLE_CYC + 1);
    localparam int RUN_AT = (NUM_STAGES + 1) * STAGE_GAP;
    localparam int GAP_W  = $clog2(RUN_AT + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                  locked_s;
    state_t                state, state_n;
    logic [STB_W-1:0]      stb_cnt, stb_cnt_n;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_n, gap_inc;
    logic [NUM_STAGES-1:0] rst_out_n;
    logic                  all_ready_n, lock_lost_n;
    logic [CNT_W-1:0]      lost_cnt_n;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (locked),
        .q   (locked_s)
    );

    assign gap_inc = gap_cnt + GAP_W'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= WAIT_LOCK;
            stb_cnt   <= '0;
            gap_cnt   <= '0;
            rst_out   <= '1;
            all_ready <= 1'b0;
            lock_lost <= 1'b0;
            lost_cnt  <= '0;
        end else begin
            state     <= state_n;
            stb_cnt   <= stb_cnt_n;
            gap_cnt   <= gap_cnt_n;
            rst_out   <= rst_out_n;
            all_ready <= all_ready_n;
            lock_lost <= lock_lost_n;
            lost_cnt  <= lost_cnt_n;
        end
    end

    // Loss of lock wins over a stage release landing on the same edge.
    always_comb begin
        state_n = state;
        case (state)
            WAIT_LOCK: if (locked_s && stb_cnt == STB_W'(STABLE_CYC)) state_n = RELEASE;
            RELEASE: begin
                if (!locked_s)                    state_n = FAULT;
                else if (gap_inc == GAP_W'(RUN_AT)) state_n = RUN;
            end
            RUN:       if (!locked_s) state_n = FAULT;
            FAULT:     state_n = WAIT_LOCK;
            default:   state_n = WAIT_LOCK;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        stb_cnt_n   = '0;
        gap_cnt_n   = '0;
        rst_out_n   = '1;
        all_ready_n = 1'b0;
        lock_lost_n = 1'b0;
        lost_cnt_n  = lost_cnt;
        case (state)
            WAIT_LOCK: begin
                if (locked_s && stb_cnt != STB_W'(STABLE_CYC)) stb_cnt_n = stb_cnt + STB_W'(1);
            end
            RELEASE: begin
                if (!locked_s) begin
                    lock_lost_n = 1'b1;
                    lost_cnt_n  = sat_inc(lost_cnt);
                end else begin
                    gap_cnt_n = gap_inc;
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        rst_out_n[k] = rst_out[k] && (gap_inc != GAP_W'((k + 1) * STAGE_GAP));
                    end
                    if (gap_inc == GAP_W'(RUN_AT)) begin
                        rst_out_n   = '0;
                        all_ready_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!locked_s) begin
                    lock_lost_n = 1'b1;
                    lost_cnt_n  = sat_inc(lost_cnt);
                end else begin
                    rst_out_n   = '0;
                    all_ready_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
    localparam int WD_TOP = TIMEOUT_CYC + AREQ_PULSE;
    localparam int WD_W   = $clog2(WD_TOP);

    logic [WD_W-1:0] wd_cnt, wd_cnt_n;
    logic            pll_areset_n;

    // Watchdog wraps after the request pulse, so it re-fires while lock stays absent.
    always_comb begin
        wd_cnt_n     = '0;
        pll_areset_n = 1'b0;
        if (state == WAIT_LOCK && state_n == WAIT_LOCK) begin
            wd_cnt_n     = (wd_cnt == WD_W'(WD_TOP - 1)) ? '0 : wd_cnt + WD_W'(1);
            pll_areset_n = (wd_cnt_n >= WD_W'(TIMEOUT_CYC));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wd_cnt     <= '0;
            pll_areset <= 1'b0;
        end else begin
            wd_cnt     <= wd_cnt_n;
            pll_areset <= pll_areset_n;
        end
    end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed self-checking bench for pll_rst_seq; watchdog test needs PLL_RST_SEQ_LOCK_TIMEOUT_EN.
module tb_pll_rst_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       locked  = 1'b0;
    logic [2:0] rst_out;
    logic       all_ready;
    logic       lock_lost;
    logic [1:0] lost_cnt;
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
    logic       pll_areset;
`endif

    int checks   = 0;
    int failures = 0;

    pll_rst_seq #(
        .NUM_STAGES  (3),
        .STABLE_CYC  (8),
        .STAGE_GAP   (4),
        .CNT_W       (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .locked    (locked),
        .rst_out   (rst_out),
        .all_ready (all_ready),
        .lock_lost (lock_lost),
        .lost_cnt  (lost_cnt)
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
        ,
        .pll_areset(pll_areset)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // obs/exp layout: {rst_out[2:0], all_ready, lock_lost, lost_cnt[1:0]}
    task automatic test_reset();
        logic [6:0] obs;
        sys_rst = 1'b1;
        locked  = 1'b0;
        tick();
        tick();
        obs = {rst_out, all_ready, lock_lost, lost_cnt};
        checks++;
        if (obs !== 7'b111_0_0_00)
            $display("FAIL reset_state got=%b want=%b", obs, 7'b111_0_0_00);
        if (obs !== 7'b111_0_0_00) failures++;
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {rst_out, all_ready, lock_lost, lost_cnt};
            checks++;
            if (obs !== 7'b111_0_0_00) begin
                failures++;
                $display("FAIL idle_unlocked cyc=%0d got=%b want=%b", i, obs, 7'b111_0_0_00);
            end
        end
    endtask

    task automatic test_power_up();
        logic [6:0] obs, exp;
        locked = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            tick();
            exp = {(e < 22), (e < 18), (e < 14), (e >= 26), 1'b0, 2'd0};
            obs = {rst_out, all_ready, lock_lost, lost_cnt};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL power_up E%0d got=%b want=%b", e, obs, exp);
            end
        end
    endtask

    task automatic test_loss_in_run();
        logic [6:0] obs, exp;
        int r;
        locked = 1'b0;
        for (int e = 0; e <= 32; e++) begin
            tick();
            if (e == 2) locked = 1'b1;
            r = e - 3;
            if (e < 2) exp = 7'b000_1_0_00;
            else exp = {(r < 22), (r < 18), (r < 14), (r >= 26), (e == 2), 2'd1};
            obs = {rst_out, all_ready, lock_lost, lost_cnt};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL loss_in_run L%0d got=%b want=%b", e, obs, exp);
            end
        end
    endtask

    task automatic test_unstable_lock();
        logic [6:0] obs, exp;
        sys_rst = 1'b1;
        locked  = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        tick();
        for (int u = 0; u <= 22; u++) begin
            locked = (u != 5);
            tick();
            exp = {2'b11, (u < 20), 1'b0, 1'b0, 2'd0};
            obs = {rst_out, all_ready, lock_lost, lost_cnt};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL unstable_lock U%0d got=%b want=%b", u, obs, exp);
            end
        end
    endtask

    task automatic test_loss_mid_release();
        logic [6:0] obs, exp;
        logic [6:0] first_tab [4];
        logic [1:0] prev_cnt, new_cnt;
        first_tab[0] = 7'b110_0_0_00;
        first_tab[1] = 7'b100_0_0_00;
        first_tab[2] = 7'b111_0_1_01;
        first_tab[3] = 7'b111_0_0_01;
        for (int d = 0; d < 4; d++) begin
            locked = (d >= 3);
            tick();
            obs = {rst_out, all_ready, lock_lost, lost_cnt};
            checks++;
            if (obs !== first_tab[d]) begin
                failures++;
                $display("FAIL loss_release_1 D%0d got=%b want=%b", d, obs, first_tab[d]);
            end
        end
        for (int n = 2; n <= 4; n++) begin
            prev_cnt = 2'(n - 1);
            new_cnt  = (n > 3) ? 2'd3 : 2'(n);
            for (int r = 1; r <= 15; r++) tick();
            obs = {rst_out, all_ready, lock_lost, lost_cnt};
            exp = {3'b110, 1'b0, 1'b0, prev_cnt};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL relock_release_%0d got=%b want=%b", n, obs, exp);
            end
            for (int d = 0; d < 4; d++) begin
                locked = (d >= 3);
                tick();
                if (d < 2) exp = {3'b110, 1'b0, 1'b0, prev_cnt};
                else       exp = {3'b111, 1'b0, (d == 2), new_cnt};
                obs = {rst_out, all_ready, lock_lost, lost_cnt};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL loss_release_%0d D%0d got=%b want=%b", n, d, obs, exp);
                end
            end
        end
    endtask

    task automatic test_sysrst_in_release();
        logic [6:0] obs, exp;
        for (int r = 1; r <= 15; r++) tick();
        obs = {rst_out, all_ready, lock_lost, lost_cnt};
        checks++;
        if (obs !== 7'b110_0_0_11) begin
            failures++;
            $display("FAIL pre_sysrst got=%b want=%b", obs, 7'b110_0_0_11);
        end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        obs = {rst_out, all_ready, lock_lost, lost_cnt};
        checks++;
        if (obs !== 7'b111_0_0_00) begin
            failures++;
            $display("FAIL sysrst_release got=%b want=%b", obs, 7'b111_0_0_00);
        end
        for (int s = 1; s <= 15; s++) begin
            tick();
            exp = {2'b11, (s < 15), 1'b0, 1'b0, 2'd0};
            obs = {rst_out, all_ready, lock_lost, lost_cnt};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL post_sysrst S%0d got=%b want=%b", s, obs, exp);
            end
        end
    endtask

`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
    task automatic test_lock_timeout();
        logic exp;
        sys_rst = 1'b1;
        locked  = 1'b0;
        tick();
        sys_rst = 1'b0;
        checks++;
        if (pll_areset !== 1'b0) begin
            failures++;
            $display("FAIL areset_reset got=%b want=0", pll_areset);
        end
        for (int k = 1; k <= 150; k++) begin
            tick();
            exp = ((k % 72) >= 64);
            checks++;
            if (pll_areset !== exp) begin
                failures++;
                $display("FAIL lock_timeout k=%0d got=%b want=%b", k, pll_areset, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_loss_in_run();
        test_unstable_lock();
        test_loss_mid_release();
        test_sysrst_in_release();
`ifdef PLL_RST_SEQ_LOCK_TIMEOUT_EN
        test_lock_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
